// File: rtl/pec_accumulator.sv
// Bit-serial shift-add accumulator for the PEC controller / CIM array column partial sums.
// Optional macro PEC_ACC_SIGNED_W_EN: two's complement weights (MSB bit-line term subtracted).
module pec_accumulator #(
  parameter int N_FEAT = 16,
  parameter int PSUM_W = 5,
  parameter int ACC_W  = 16,
  parameter int N_WBIT = 4,
  parameter int N_IBIT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_acc_i,
  input  logic                     trigger_acc_i,
  input  logic [N_FEAT*PSUM_W-1:0] psum_i,
  input  logic                     bias_we_i,
  input  logic [3:0]               bias_idx_i,
  input  logic [ACC_W-1:0]         bias_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [N_FEAT*ACC_W-1:0]  out_data_o,
  output logic                     busy_o,
  output logic                     overrun_o
);
  // state | meaning
  // IDLE  | waiting for trigger_acc_i; accumulators keep their running sum
  // ACCUM | consuming beats 1..N_BEATS-1 of a pass (beat 0 is taken on the trigger)

  localparam int N_BEATS = N_WBIT * N_IBIT;
  localparam int BEAT_W  = $clog2(N_BEATS);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e            state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat;
  logic              beat_en;
  logic              last_beat;
  logic [ACC_W-1:0]  acc_q  [N_FEAT];
  logic [ACC_W-1:0]  acc_d  [N_FEAT];
  logic [ACC_W-1:0]  bias_q [N_FEAT];

  always_comb begin
    beat      = (state_q == ACCUM) ? beat_q : '0;
    beat_en   = !clear_acc_i && ((state_q == ACCUM) || trigger_acc_i);
    last_beat = beat_en && (beat == BEAT_W'(N_BEATS - 1));
  end

  // Bit-line index is the fast digit of the beat, input bit the slow one.
  always_comb begin
    int               w_idx;
    int               shamt;
    logic [ACC_W-1:0] term;
    w_idx = int'(beat) % N_WBIT;
    shamt = w_idx + int'(beat) / N_WBIT;
    term  = '0;
    for (int f = 0; f < N_FEAT; f++) begin
      term = ACC_W'(psum_i[f*PSUM_W +: PSUM_W]) << shamt;
`ifdef PEC_ACC_SIGNED_W_EN
      acc_d[f] = (w_idx == N_WBIT - 1) ? acc_q[f] - term : acc_q[f] + term;
`else
      acc_d[f] = acc_q[f] + term;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
      out_data_o  <= '0;
      for (int f = 0; f < N_FEAT; f++) begin
        acc_q[f]  <= '0;
        bias_q[f] <= '0;
      end
    end else begin
      if (bias_we_i && (int'(bias_idx_i) < N_FEAT)) bias_q[bias_idx_i] <= bias_i;

      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;

      if (clear_acc_i) begin
        state_q   <= IDLE;
        beat_q    <= '0;
        busy_o    <= 1'b0;
        overrun_o <= 1'b0;
        for (int f = 0; f < N_FEAT; f++) acc_q[f] <= bias_q[f];
      end else if (beat_en) begin
        for (int f = 0; f < N_FEAT; f++) acc_q[f] <= acc_d[f];
        if (last_beat) begin
          state_q     <= IDLE;
          beat_q      <= '0;
          busy_o      <= 1'b0;
          out_valid_o <= 1'b1;
          // A same-cycle handshake frees the slot, so only an unaccepted result overruns.
          if (out_valid_o && !out_ready_i) overrun_o <= 1'b1;
          for (int f = 0; f < N_FEAT; f++) out_data_o[f*ACC_W +: ACC_W] <= acc_d[f];
        end else begin
          state_q <= ACCUM;
          beat_q  <= beat + 1'b1;
          busy_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pec_accumulator.md
Name: pec_accumulator

Overview:
- Bit-serial shift-add accumulator directly downstream of the PEC controller and CIM array.
- Consumes the controller's `trigger_acc`/`clear_acc` strobes and the per-feature column partial sums produced during a compute pass (4 weight bit-lines × 4 input bits = 16 beats).
- Reconstructs the multi-bit dot product per feature, pre-loaded with a per-feature bias.
- Presents the results to the sink stage over a valid/ready handshake.

Parameters:
- N_FEAT, 16, number of feature accumulators (array column groups).
- PSUM_W, 5, width of each unsigned column partial sum (9 pixels → 0..9 fits).
- ACC_W, 16, accumulator, bias and output width; arithmetic wraps modulo 2^ACC_W.
- N_WBIT, 4, weight bits per pass (bit-line steps).
- N_IBIT, 4, input bits per pass (in_bit steps).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_acc_i  in  1  load accumulators with bias, abort any pass.
- trigger_acc_i  in  1  one-cycle strobe marking beat 0 of a pass.
- psum_i  in  N_FEAT×PSUM_W  column partial sums, one per feature, valid every beat.
- bias_we_i  in  1  write bias_i into bias register bias_idx_i.
- bias_idx_i  in  4  bias register index (0..N_FEAT-1; values ≥ N_FEAT ignored).
- bias_i  in  ACC_W  bias value, two's complement.
- out_valid_o  out  1  out_data_o holds a completed pass result.
- out_ready_i  in  1  sink accepts out_data_o.
- out_data_o  out  N_FEAT×ACC_W  snapshot of accumulators at end of pass.
- busy_o  out  1  pass in progress.
- overrun_o  out  1  sticky: a pass completed while the previous result was unaccepted.

Behaviour:
- Reset: state IDLE; beat counter 0; accumulators, bias regs and out_data_o = 0; out_valid_o, busy_o, overrun_o = 0.
- FSM states: IDLE, ACCUM.
  - IDLE→ACCUM on trigger_acc_i (beat 0 is consumed in the same cycle).
  - ACCUM→IDLE after beat N_WBIT·N_IBIT−1.
- Beat k (0..15): w = k mod N_WBIT, i = k div N_WBIT, matching the controller order (bit-line fastest).
  - acc[f] += zero-extended psum_i[f] << (w+i), for every f, computed at ACC_W.
- busy_o = 1 in ACCUM.
  - trigger_acc_i during ACCUM is ignored and does not restart the counter.
- Completion, at the clock edge of beat 15:
  - out_data_o ← final accumulator values, including beat 15.
  - out_valid_o = 1 from the next cycle.
  - Latency: 16 cycles from trigger to out_valid_o.
- Accumulators are not cleared at pass end, so successive passes sum (multi-channel accumulation) until clear_acc_i.
- Handshake:
  - out_valid_o drops the cycle after out_valid_o && out_ready_i.
  - out_data_o is stable while out_valid_o && !out_ready_i.
- Overrun: if a completion occurs while out_valid_o && !out_ready_i, out_data_o is overwritten, out_valid_o stays 1, and overrun_o ← 1 (sticky until clear_acc_i or reset).
  - If the handshake fires in the same cycle as a completion, there is no overrun and out_valid_o stays 1 with the new data.
- clear_acc_i has highest priority:
  - acc[f] ← bias[f]; state → IDLE; beat counter 0; overrun_o ← 0.
  - out_valid_o and out_data_o are unaffected.
  - A simultaneous trigger_acc_i is dropped.
- bias_we_i takes effect at the next edge. When bias_we_i coincides with clear_acc_i, clear uses the old bias value.
- Reset mid-pass: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro PEC_ACC_SIGNED_W_EN.
- Defined: weights are two's complement. On beats with w = N_WBIT−1, the shifted term is subtracted instead of added.
- Undefined: weights are unsigned and all terms are added.

Test Plan:
- Reset → all outputs 0.
  - bias[3]=10, clear_acc_i, trigger, psum_i[3]=1 for 16 beats → out_data_o[3]=235 (10+225) exactly 16 cycles after trigger; out_valid_o=1.
- psum_i[0]=9 all beats, bias 0, unsigned build → out_data_o[0]=2025.
  - With PEC_ACC_SIGNED_W_EN and psum=1 → out_data_o[0]=0xFFF1 (−15).
- Two passes without clear, psum=1, out_ready_i=1 → second result 450.
  - Then clear with bias 0 → next pass 225.
- out_ready_i=0 across two completed passes → overrun_o=1 and out_data_o = second result.
  - Then clear_acc_i → overrun_o=0.
- Second trigger at beat 7 → ignored; completion still at cycle 16.
  - clear_acc_i at beat 10 → busy_o=0 next cycle and no out_valid_o.
- rst_ni low at beat 5 → immediate zero outputs; a fresh trigger afterwards yields the correct single-pass result.
